// File: rtl/btb_pkg.sv
// Shared types and constants for the branch target buffer.
package btb_pkg;

    localparam int unsigned PC_W = 16;

    localparam logic [1:0] CTR_SNT         = 2'b00;
    localparam logic [1:0] CTR_WNT         = 2'b01;
    localparam logic [1:0] CTR_WT          = 2'b10;
    localparam logic [1:0] CTR_ST          = 2'b11;
    localparam logic [1:0] CTR_RESET       = CTR_WNT;
    localparam logic [1:0] CTR_ALLOC_TAKEN = CTR_WT;

    // Tag is held right-aligned in a full-width field so the type is independent of table depth.
    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] tag;
        logic [PC_W-1:0] target;
        logic [1:0]      ctr;
    } btb_entry_t;

endpackage

// File: rtl/btb_ctr2.sv
// 2-bit saturating branch counter next-state; jumps force strongly taken.
module btb_ctr2
    import btb_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_taken,
    input  logic       i_jump,
    output logic [1:0] o_next_c
);

    always_comb begin
        o_next_c = i_ctr;
        if (i_jump) begin
            o_next_c = CTR_ST;
        end else if (i_taken) begin
            if (i_ctr != CTR_ST) o_next_c = i_ctr + 2'd1;
        end else begin
            if (i_ctr != CTR_SNT) o_next_c = i_ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup, edge-registered update.
// Optional perf counters (perf_hits, perf_mispred) under `define BTB_PERF_EN.
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int unsigned ENTRIES = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lookup_valid,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_next_pc,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_taken,
    input  logic            upd_jump,
    input  logic            upd_mispredict,
    input  logic            inv_all
`ifdef BTB_PERF_EN
    ,
    output logic [15:0]     perf_hits,
    output logic [15:0]     perf_mispred
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    btb_entry_t r_table [ENTRIES];

    logic [IDX_W-1:0] w_lk_idx;
    logic [PC_W-1:0]  w_lk_tag;
    btb_entry_t       w_lk_entry;
    logic [IDX_W-1:0] w_up_idx;
    logic [PC_W-1:0]  w_up_tag;
    btb_entry_t       w_up_entry;
    logic             w_up_hit;
    logic             w_up_taken;
    logic             w_up_write;
    logic [1:0]       w_ctr_next;
    btb_entry_t       w_up_new;

    // Lookup reads registered state only; a same-cycle update is not bypassed.
    assign w_lk_idx     = lookup_pc[IDX_W:1];
    assign w_lk_tag     = PC_W'(lookup_pc >> (IDX_W + 1));
    assign w_lk_entry   = r_table[w_lk_idx];
    assign pred_hit     = lookup_valid & w_lk_entry.valid & (w_lk_entry.tag == w_lk_tag);
    assign pred_taken   = pred_hit & w_lk_entry.ctr[1];
    assign pred_next_pc = pred_taken ? w_lk_entry.target : lookup_pc + PC_W'(2);

    assign w_up_idx   = upd_pc[IDX_W:1];
    assign w_up_tag   = PC_W'(upd_pc >> (IDX_W + 1));
    assign w_up_entry = r_table[w_up_idx];
    assign w_up_hit   = w_up_entry.valid & (w_up_entry.tag == w_up_tag);
    assign w_up_taken = upd_taken | upd_jump;
    assign w_up_write = upd_valid & (w_up_hit | w_up_taken);

    btb_ctr2 u_ctr2 (
        .i_ctr    (w_up_entry.ctr),
        .i_taken  (w_up_taken),
        .i_jump   (upd_jump),
        .o_next_c (w_ctr_next)
    );

    // New entry contents: train on hit, allocate on taken miss.
    always_comb begin
        w_up_new       = w_up_entry;
        w_up_new.valid = 1'b1;
        w_up_new.tag   = w_up_tag;
        if (w_up_taken) w_up_new.target = upd_target;
        if (w_up_hit)        w_up_new.ctr = w_ctr_next;
        else if (upd_jump)   w_up_new.ctr = CTR_ST;
        else                 w_up_new.ctr = CTR_ALLOC_TAKEN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || inv_all) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                r_table[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
            end
        end else if (w_up_write) begin
            r_table[w_up_idx] <= w_up_new;
        end
    end

`ifdef BTB_PERF_EN
    logic [15:0] r_perf_hits;
    logic [15:0] r_perf_mispred;

    // Saturating event counters; inv_all leaves them alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_hits    <= '0;
            r_perf_mispred <= '0;
        end else begin
            if (pred_hit && r_perf_hits != 16'hFFFF) r_perf_hits <= r_perf_hits + 16'd1;
            if (upd_valid && upd_mispredict && r_perf_mispred != 16'hFFFF)
                r_perf_mispred <= r_perf_mispred + 16'd1;
        end
    end

    assign perf_hits    = r_perf_hits;
    assign perf_mispred = r_perf_mispred;
`else
    logic w_unused_mispredict;
    assign w_unused_mispredict = upd_mispredict;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer against an array-based predictor model.
module tb_branch_target_buffer;

    localparam int ENTRIES = 8;
    localparam int IDX_W   = 3;

    logic        clk = 1'b0;
    logic        rst_n, lookup_valid, upd_valid, upd_taken, upd_jump, upd_mispredict, inv_all;
    logic [15:0] lookup_pc, upd_pc, upd_target;
    logic        pred_hit, pred_taken;
    logic [15:0] pred_next_pc;
`ifdef BTB_PERF_EN
    logic [15:0] perf_hits, perf_mispred;
`endif

    int total = 0;
    int bad   = 0;

    bit m_valid  [ENTRIES];
    int m_tag    [ENTRIES];
    int m_target [ENTRIES];
    int m_ctr    [ENTRIES];
    int m_hits, m_mis;

    always #5 clk = ~clk;

    branch_target_buffer #(.ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst_n(rst_n), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_jump(upd_jump), .upd_mispredict(upd_mispredict),
        .inv_all(inv_all)
`ifdef BTB_PERF_EN
        , .perf_hits(perf_hits), .perf_mispred(perf_mispred)
`endif
    );

    // Expected {hit, taken, next_pc} for the current lookup inputs.
    function automatic logic [17:0] m_pred();
        int idx = (int'(lookup_pc) / 2) % ENTRIES;
        int tag = int'(lookup_pc) >> (IDX_W + 1);
        bit hit = lookup_valid && m_valid[idx] && (m_tag[idx] == tag);
        bit tk  = hit && (m_ctr[idx] >= 2);
        int nxt = tk ? m_target[idx] : ((int'(lookup_pc) + 2) % 65536);
        return {hit, tk, 16'(nxt)};
    endfunction

    task automatic m_clear();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
    endtask

    task automatic model_commit();
        logic [17:0] p = m_pred();
        int idx = (int'(upd_pc) / 2) % ENTRIES;
        int tag = int'(upd_pc) >> (IDX_W + 1);
        bit tk  = upd_taken || upd_jump;
        if (!rst_n) begin
            m_clear();
            m_hits = 0;
            m_mis  = 0;
            return;
        end
        if (p[17] && m_hits < 65535) m_hits++;
        if (upd_valid && upd_mispredict && m_mis < 65535) m_mis++;
        if (inv_all) begin
            m_clear();
        end else if (upd_valid) begin
            if (m_valid[idx] && m_tag[idx] == tag) begin
                if (upd_jump)  m_ctr[idx] = 3;
                else if (tk)   m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
                else           m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
                if (tk) m_target[idx] = int'(upd_target);
            end else if (tk) begin
                m_valid[idx]  = 1'b1;
                m_tag[idx]    = tag;
                m_target[idx] = int'(upd_target);
                m_ctr[idx]    = upd_jump ? 3 : 2;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle();
        upd_valid = 0; upd_taken = 0; upd_jump = 0; upd_mispredict = 0; inv_all = 0;
    endtask

    task automatic upd(input logic [15:0] pc, input logic [15:0] tgt, input bit tk, input bit jmp);
        upd_valid = 1; upd_pc = pc; upd_target = tgt; upd_taken = tk | jmp; upd_jump = jmp;
        tick();
        idle();
    endtask

    task automatic test_reset();
        logic [17:0] e;
        rst_n = 0; lookup_valid = 1; lookup_pc = 16'h0010;
        upd_pc = 0; upd_target = 0; idle();
        tick(); tick();
        rst_n = 1;
        foreach (e[i]) e[i] = 1'b0;
        @(negedge clk);
        e = {2'b00, 16'h0012};
        if ({pred_hit, pred_taken, pred_next_pc} !== e) begin
            bad++; $display("FAIL reset_lookup got=%h want=%h", {pred_hit, pred_taken, pred_next_pc}, e);
        end
        total++;
        lookup_pc = 16'hFFFE;
        #1;
        e = {2'b00, 16'h0000};
        if ({pred_hit, pred_taken, pred_next_pc} !== e) begin
            bad++; $display("FAIL reset_wrap got=%h want=%h", {pred_hit, pred_taken, pred_next_pc}, e);
        end
        total++;
`ifdef BTB_PERF_EN
        if ({perf_hits, perf_mispred} !== 32'h0) begin
            bad++; $display("FAIL reset_perf got=%h want=0", {perf_hits, perf_mispred});
        end
        total++;
`endif
        tick();
    endtask

    task automatic test_train();
        logic [17:0] e;
        lookup_pc = 16'h0010;
        upd(16'h0010, 16'h0040, 1, 0);
        @(negedge clk); e = {2'b11, 16'h0040};
        if ({pred_hit, pred_taken, pred_next_pc} !== e) begin
            bad++; $display("FAIL alloc_hit got=%h want=%h", {pred_hit, pred_taken, pred_next_pc}, e);
        end
        total++;
        tick(); upd(16'h0010, 16'h0000, 0, 0); upd(16'h0010, 16'h0000, 0, 0);
        @(negedge clk); e = {2'b10, 16'h0012};
        if ({pred_hit, pred_taken, pred_next_pc} !== e) begin
            bad++; $display("FAIL ctr_down got=%h want=%h", {pred_hit, pred_taken, pred_next_pc}, e);
        end
        total++;
        tick();
        for (int i = 0; i < 4; i++) upd(16'h0010, 16'h0040, 1, 0);
        upd(16'h0010, 16'h0000, 0, 0);
        @(negedge clk); e = {2'b11, 16'h0040};
        if ({pred_hit, pred_taken, pred_next_pc} !== e) begin
            bad++; $display("FAIL ctr_saturate got=%h want=%h", {pred_hit, pred_taken, pred_next_pc}, e);
        end
        total++;
        tick();
    endtask

    task automatic test_alias_jump();
        logic [17:0] e;
        upd(16'h0020, 16'h0100, 1, 0);
        lookup_pc = 16'h0010;
        @(negedge clk); e = {2'b00, 16'h0012};
        if ({pred_hit, pred_taken, pred_next_pc} !== e) begin
            bad++; $display("FAIL alias_old got=%h want=%h", {pred_hit, pred_taken, pred_next_pc}, e);
        end
        total++;
        lookup_pc = 16'h0020; #1; e = {2'b11, 16'h0100};
        if ({pred_hit, pred_taken, pred_next_pc} !== e) begin
            bad++; $display("FAIL alias_new got=%h want=%h", {pred_hit, pred_taken, pred_next_pc}, e);
        end
        total++;
        tick();
        upd(16'h0020, 16'h0000, 0, 0); upd(16'h0020, 16'h0000, 0, 0);
        upd(16'h0020, 16'h0200, 1, 1); upd(16'h0020, 16'h0000, 0, 0);
        @(negedge clk); e = {2'b11, 16'h0200};
        if ({pred_hit, pred_taken, pred_next_pc} !== e) begin
            bad++; $display("FAIL jump_strong got=%h want=%h", {pred_hit, pred_taken, pred_next_pc}, e);
        end
        total++;
        tick();
    endtask

    task automatic test_same_cycle_inv();
        logic [17:0] e;
        inv_all = 1; tick(); idle();
        lookup_pc = 16'h0030;
        upd_valid = 1; upd_pc = 16'h0030; upd_target = 16'h0300; upd_taken = 1;
        @(negedge clk); e = {2'b00, 16'h0032};
        if ({pred_hit, pred_taken, pred_next_pc} !== e) begin
            bad++; $display("FAIL no_bypass got=%h want=%h", {pred_hit, pred_taken, pred_next_pc}, e);
        end
        total++;
        tick(); idle();
        @(negedge clk); e = {2'b11, 16'h0300};
        if ({pred_hit, pred_taken, pred_next_pc} !== e) begin
            bad++; $display("FAIL next_cycle got=%h want=%h", {pred_hit, pred_taken, pred_next_pc}, e);
        end
        total++;
        tick();
        inv_all = 1; upd_valid = 1; upd_pc = 16'h0030; upd_target = 16'h0500; upd_taken = 1;
        tick(); idle();
        @(negedge clk); e = {2'b00, 16'h0032};
        if ({pred_hit, pred_taken, pred_next_pc} !== e) begin
            bad++; $display("FAIL inv_priority got=%h want=%h", {pred_hit, pred_taken, pred_next_pc}, e);
        end
        total++;
        tick();
    endtask

    task automatic test_random();
        logic [17:0] e;
        for (int c = 0; c < 600; c++) begin
            rst_n          = ($urandom_range(0, 99) != 0);
            inv_all        = ($urandom_range(0, 39) == 0);
            lookup_valid   = ($urandom_range(0, 5) != 0);
            lookup_pc      = ($urandom_range(0, 7) == 0) ? 16'(16'hFFF0 + 2 * $urandom_range(0, 7))
                                                         : 16'(2 * $urandom_range(0, 31));
            upd_valid      = $urandom_range(0, 1);
            upd_pc         = ($urandom_range(0, 1) != 0) ? lookup_pc : 16'(2 * $urandom_range(0, 31));
            upd_target     = 16'($urandom);
            upd_jump       = ($urandom_range(0, 7) == 0);
            upd_taken      = upd_jump | 1'($urandom_range(0, 1));
            upd_mispredict = $urandom_range(0, 1);
            @(negedge clk);
            e = m_pred();
            if ({pred_hit, pred_taken, pred_next_pc} !== e) begin
                bad++; $display("FAIL rand_pred c=%0d pc=%h got=%h want=%h", c, lookup_pc,
                                {pred_hit, pred_taken, pred_next_pc}, e);
            end
            total++;
`ifdef BTB_PERF_EN
            if ({perf_hits, perf_mispred} !== {16'(m_hits), 16'(m_mis)}) begin
                bad++; $display("FAIL rand_perf c=%0d got=%h want=%h", c, {perf_hits, perf_mispred},
                                {16'(m_hits), 16'(m_mis)});
            end
            total++;
`endif
            tick();
        end
        rst_n = 1; idle();
    endtask

`ifdef BTB_PERF_EN
    task automatic test_perf();
        rst_n = 0; lookup_valid = 0; tick(); rst_n = 1;
        upd(16'h0010, 16'h0040, 1, 0);
        lookup_valid = 1; lookup_pc = 16'h0010;
        for (int i = 0; i < 3; i++) begin
            upd_valid = (i < 2); upd_pc = 16'h0002; upd_taken = 0; upd_mispredict = 1;
            tick();
        end
        idle(); lookup_valid = 0;
        @(negedge clk);
        if ({perf_hits, perf_mispred} !== {16'd3, 16'd2}) begin
            bad++; $display("FAIL perf_count got=%h want=%h", {perf_hits, perf_mispred}, {16'd3, 16'd2});
        end
        total++;
        tick();
        lookup_valid = 1; upd_valid = 1; upd_pc = 16'h0002; upd_taken = 0; upd_mispredict = 1;
        for (int i = 0; i < 65540; i++) tick();
        idle(); inv_all = 1; tick(); idle(); lookup_valid = 0;
        @(negedge clk);
        if ({perf_hits, perf_mispred} !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL perf_saturate got=%h want=ffffffff", {perf_hits, perf_mispred});
        end
        total++;
        rst_n = 0; tick(); rst_n = 1;
        @(negedge clk);
        if ({perf_hits, perf_mispred} !== 32'h0) begin
            bad++; $display("FAIL perf_reset got=%h want=0", {perf_hits, perf_mispred});
        end
        total++;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_train();
        test_alias_jump();
        test_same_cycle_inv();
        test_random();
`ifdef BTB_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Fetch-stage branch predictor for the 5-stage pipeline: supplies a predicted next PC for the instruction being fetched and learns from branch outcomes resolved in the execute stage. It is the prediction side of branch handling. The execute-stage branch comparator issues resolved outcomes and flushes, and this block issues the predictions those outcomes are checked against. The block is a direct-mapped table with per-entry tag, target and 2-bit saturating counter.

## Interface
- ENTRIES, 8: table depth; power of two, 2..64.
- IDX_W, $clog2(ENTRIES): index width (derived, not overridden).
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- lookup_valid  in  1  fetch PC is valid this cycle.
- lookup_pc  in  16  fetch PC, byte address, instructions 2 bytes.
- pred_hit  out  1  tag match on a valid entry.
- pred_taken  out  1  predict taken.
- pred_next_pc  out  16  predicted next fetch PC.
- upd_valid  in  1  a branch/jump resolved this cycle.
- upd_pc  in  16  PC of the resolved instruction.
- upd_target  in  16  resolved target.
- upd_taken  in  1  branch was taken (1 for jumps).
- upd_jump  in  1  instruction is an unconditional jump.
- upd_mispredict  in  1  resolved outcome disagreed with prediction (perf only).
- inv_all  in  1  invalidate whole table.

## Operation
- Index = PC[IDX_W:1]; tag = PC[15:IDX_W+1]. PC[0] is ignored.
- Entry fields: valid, tag, target[15:0], ctr[1:0] (00 SNT, 01 WNT, 10 WT, 11 ST).
- Lookup is combinational from registered table state:
  - pred_hit = lookup_valid & valid[idx] & tag match.
  - pred_taken = pred_hit & ctr[1].
  - pred_next_pc = pred_taken ? target : lookup_pc + 2, mod 2^16; 0xFFFE+2 wraps to 0x0000.
- Update on the rising edge when upd_valid=1:
  - Hit, upd_jump=1: ctr := 11, target := upd_target.
  - Hit, taken: ctr saturating increment, target := upd_target.
  - Hit, not taken: ctr saturating decrement; target unchanged.
  - Miss, taken: allocate/replace: valid := 1, tag, target := upd_target, ctr := 10; jump allocates with 11.
  - Miss, not taken: no change.
- Priority on the same edge: rst_n=0 > inv_all=1 > update.
- Reset and inv_all clear all valid bits and set every ctr to 01. Targets and tags are don't-care after reset.

## Timing
- Lookup latency 0 cycles.
- An update written at edge N is visible to lookups from cycle N+1. A same-cycle lookup at the same index sees pre-update contents; there is no bypass.
- Reset values: all entries invalid. With lookup_valid=1, pred_hit=0, pred_taken=0, pred_next_pc=lookup_pc+2. Perf counters read 0.
- Reset asserted mid-stream: the table is cleared at that edge, and any concurrent update is discarded.
- No handshake: upd_valid is a single-cycle strobe and is accepted every cycle.

## Configuration
- BTB_PERF_EN defined: adds outputs perf_hits[15:0] (+1 per cycle with pred_hit=1) and perf_mispred[15:0] (+1 per upd_valid & upd_mispredict).
  - Both counters saturate at 0xFFFF.
  - Both are cleared only by rst_n, not by inv_all.
- BTB_PERF_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Package btb_pkg holds:
  - The entry struct typedef.
  - Counter encoding constants CTR_SNT/CTR_WNT/CTR_WT/CTR_ST.
  - CTR_RESET (=CTR_WNT) and CTR_ALLOC_TAKEN (=CTR_WT).
  - The PC width constant (16).
- One sub-module, btb_ctr2: combinational 2-bit saturating next-state given current ctr, taken and jump. It is shared by the update path and unit-testable alone.

## Test plan
- Reset, then lookup_pc=0x0010 -> pred_hit=0, pred_taken=0, pred_next_pc=0x0012.
- Update pc=0x0010, taken, target=0x0040; next-cycle lookup 0x0010 -> hit=1, taken=1, next_pc=0x0040.
- Same entry: two not-taken updates -> ctr 10→01→00, lookup next_pc=0x0012. Three taken updates -> ctr 11, and a fourth stays at 11.
- Alias: update pc=0x0020 taken target=0x0100 (idx 0, tag 0x002) replaces the entry. Lookup 0x0010 -> miss; lookup 0x0020 -> next_pc=0x0100.
- Same-cycle update and lookup at 0x0030 on an empty table -> hit=0 that cycle, hit=1 the next cycle. inv_all alongside upd_valid -> table empty afterwards.
- BTB_PERF_EN: 3 hit cycles and 2 mispredict strobes -> perf_hits=3, perf_mispred=2. Preload near saturation via 0xFFFF hits -> stays at 0xFFFF.
